// File: rtl/fetch_pc_unit.sv
// Fetch PC register plus a small {PC, instruction} queue toward decode.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] nxt_pc,
  input  logic        flush_D_E,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_vld,
  output logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        valid_D,
  input  logic        ready_D,
  output logic [31:0] pcD,
  output logic [31:0] instrD,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  logic [31:0]   r_pc;
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [31:0]   w_nxt_aligned;
  logic [CW-1:0] w_count_nxt;

  assign w_empty       = (r_count == {CW{1'b0}});
  assign w_pop         = !w_empty && ready_D && !flush_D_E;
  assign w_push        = imem_vld && !flush_D_E && ((r_count < FULL_CNT) || w_pop);
  assign w_nxt_aligned = {nxt_pc[31:2], 2'b00};
  assign w_count_nxt   = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (flush_D_E) begin
      // A redirect discards everything queued plus the word currently at pcF.
      r_pc    <= w_nxt_aligned;
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_pc   <= w_nxt_aligned;
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Queue storage needs no reset: the head is masked to PC 0 / NOP whenever empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]    <= r_pc;
      r_fifo_instr[r_wptr] <= imem_rdata;
    end
  end

  assign imem_addr = r_pc;
  assign pcF       = r_pc;
  assign instrF    = imem_rdata;
  assign valid_D   = !w_empty;
  assign pcD       = w_empty ? 32'h0000_0000 : r_fifo_pc[r_rptr];
  assign instrD    = w_empty ? NOP : r_fifo_instr[r_rptr];

`ifdef FETCH_PERF_CNT_EN
  logic        w_stall;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  assign w_stall = imem_vld && (r_count == FULL_CNT) && !w_pop && !flush_D_E;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 32'h0000_0000;
      r_flush_cnt <= 32'h0000_0000;
    end else begin
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (flush_D_E) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`else
  assign perf_stall_cnt = 32'h0000_0000;
  assign perf_flush_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus pushes expected decode PCs,
// a negedge monitor pops and compares on every decode handshake.
module tb_fetch_pc_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] nxt_pc;
  logic        flush_D_E;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_vld;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        valid_D;
  logic        ready_D;
  logic [31:0] pcD;
  logic [31:0] instrD;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  fetch_pc_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .nxt_pc(nxt_pc), .flush_D_E(flush_D_E),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_vld(imem_vld),
    .pcF(pcF), .instrF(instrF), .valid_D(valid_D), .ready_D(ready_D),
    .pcD(pcD), .instrD(instrD),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory model: a distinct word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000 ^ {a[7:0], 24'h00_0000};
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  int          m_cnt;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
    return v;
`else
    return 32'h0000_0000;
`endif
  endfunction

  // Monitor: every accepted decode head must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && valid_D && ready_D && !flush_D_E) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL decode_unexpected: got pc %h expected no output", pcD);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check32("decode_pc", pcD, e);
        check32("decode_instr", instrD, mem_word(e));
      end
    end
  end

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_cnt   = 0;
    m_stall = 32'h0;
    m_flush = 32'h0;
    exp_q.delete();
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic cyc(input logic vld, input logic rdy, input logic fl, input logic [31:0] nxt);
    logic push, pop, stall;
    imem_vld  = vld;
    ready_D   = rdy;
    flush_D_E = fl;
    nxt_pc    = nxt;
    @(negedge clk);
    check32("pcF", pcF, m_pc);
    check32("imem_addr", imem_addr, m_pc);
    check32("instrF", instrF, mem_word(m_pc));
    check32("valid_D", {31'h0, valid_D}, {31'h0, (m_cnt != 0)});
    if (m_cnt == 0) begin
      check32("empty_pcD", pcD, 32'h0000_0000);
      check32("empty_instrD", instrD, NOP);
    end
    check32("perf_stall", perf_stall_cnt, perf_exp(m_stall));
    check32("perf_flush", perf_flush_cnt, perf_exp(m_flush));
    #1;
    pop   = (m_cnt > 0) && rdy && !fl;
    push  = vld && !fl && ((m_cnt < DEPTH) || pop);
    stall = vld && (m_cnt == DEPTH) && !pop && !fl;
    if (fl) m_flush = m_flush + 32'd1;
    if (stall) m_stall = m_stall + 32'd1;
    if (fl) begin
      m_cnt = 0;
      exp_q.delete();
      m_pc = {nxt[31:2], 2'b00};
    end else begin
      if (push) begin
        exp_q.push_back(m_pc);
        m_pc = {nxt[31:2], 2'b00};
      end
      m_cnt = m_cnt + int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic vld, input logic rdy);
    cyc(vld, rdy, 1'b0, m_pc + 32'd4);
  endtask

  initial begin
    rst       = 1'b1;
    imem_vld  = 1'b0;
    ready_D   = 1'b0;
    flush_D_E = 1'b0;
    nxt_pc    = 32'h0;
    model_reset();
    #2;
    check32("rst_pcF", pcF, RESET_PC);
    check32("rst_valid_D", {31'h0, valid_D}, 32'h0);
    check32("rst_pcD", pcD, 32'h0);
    check32("rst_instrD", instrD, NOP);
    check32("rst_perf_stall", perf_stall_cnt, 32'h0);
    check32("rst_perf_flush", perf_flush_cnt, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-pressure: PCs 0 and 4 queued, fetch stalls at 8 for three cycles.
    repeat (5) step(1'b1, 1'b0);
    check32("stall_pcF", pcF, 32'h0000_0008);
    check32("stall_head_pcD", pcD, 32'h0000_0000);
    check32("stall_cnt3", perf_stall_cnt, perf_exp(32'd3));

    // Release: full queue pushes and pops together while fetch advances.
    repeat (6) step(1'b1, 1'b1);

    // Fill, then redirect to 0x100 with two entries queued.
    step(1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    check32("flush_valid_D", {31'h0, valid_D}, 32'h0);
    check32("flush_pcF", pcF, 32'h0000_0100);
    check32("flush_cnt1", perf_flush_cnt, perf_exp(32'd1));
    step(1'b1, 1'b0);
    check32("redirect_pcD", pcD, 32'h0000_0100);
    step(1'b1, 1'b1);

    // Misaligned predictor target is forced to word alignment.
    cyc(1'b1, 1'b1, 1'b0, 32'h0000_0103);
    check32("align_pcF", pcF, 32'h0000_0100);

    // No valid fetch word: PC holds while the queue drains.
    repeat (3) step(1'b0, 1'b1);

    // Asynchronous reset while full.
    repeat (3) step(1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check32("arst_valid_D", {31'h0, valid_D}, 32'h0);
    check32("arst_pcF", pcF, RESET_PC);
    check32("arst_pcD", pcD, 32'h0);
    check32("arst_instrD", instrD, NOP);
    check32("arst_perf_stall", perf_stall_cnt, 32'h0);
    check32("arst_perf_flush", perf_flush_cnt, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    repeat (4) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    check32("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
